// File: rtl/if_id_elastic_reg_if.sv
// IF/ID handshake bundle: fetch-side entry, decode-side entry, and pipeline hold/discard controls.
// The master modport is the environment driving the register; slave is the register itself.
interface if_id_elastic_reg_if #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc4;
   logic [INST_W-1:0] in_inst;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc4;
   logic [INST_W-1:0] out_inst;
   logic              stall;
   logic              flush;

   modport master (
      output in_valid, in_pc4, in_inst, out_ready, stall, flush,
      input  in_ready, out_valid, out_pc4, out_inst
   );

   modport slave (
      input  in_valid, in_pc4, in_inst, out_ready, stall, flush,
      output in_ready, out_valid, out_pc4, out_inst
   );
endinterface

// File: rtl/if_id_elastic_reg.sv
// Two-entry elastic IF/ID pipeline register (main + skid) with stall, flush and a
// saturating count of cycles in which decode was ready but starved.
module if_id_elastic_reg #(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
   parameter int                CNT_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   if_id_elastic_reg_if.slave bus,
   output logic [CNT_W-1:0]   bubble_cnt
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t            state, state_nxt;
   logic              in_fire, out_fire;
   logic              load_main, main_from_skid, load_skid;
   logic [PC_W-1:0]   main_pc4, skid_pc4;
   logic [INST_W-1:0] main_inst, skid_inst;

   // Handshake outputs decode the state flop only, so no path from out_ready/stall/flush.
   assign bus.in_ready  = (state != TWO);
   assign bus.out_valid = (state != EMPTY);

   assign in_fire  = bus.in_valid & bus.in_ready;
   assign out_fire = bus.out_valid & bus.out_ready & ~bus.stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      state_nxt      = state;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (bus.flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_fire) begin
               load_main = 1'b1;
               state_nxt = ONE;
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (in_fire) begin
                  load_skid = 1'b1;
                  state_nxt = TWO;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: if (out_fire) begin
               main_from_skid = 1'b1;
               state_nxt      = ONE;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // NOTE: payload registers carry no reset; outputs are masked whenever out_valid is low.
   always_ff @(posedge clk) begin
      if (load_main) begin
         main_pc4  <= bus.in_pc4;
         main_inst <= bus.in_inst;
      end else if (main_from_skid) begin
         main_pc4  <= skid_pc4;
         main_inst <= skid_inst;
      end
      if (load_skid) begin
         skid_pc4  <= bus.in_pc4;
         skid_inst <= bus.in_inst;
      end
   end

   assign bus.out_pc4  = bus.out_valid ? main_pc4  : '0;
   assign bus.out_inst = bus.out_valid ? main_inst : NOP_INST;

   // Starved-decode counter survives flush; only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_cnt <= '0;
      end else if (bus.out_ready && !bus.out_valid && !bus.stall && (bubble_cnt != '1)) begin
         bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule
